mux_tree_pipe_n: RTL and testbench

//   Parametrised, pipelined 2**ADDR:1 mux tree for N-bit data. Built as S levels of
//   2**LVL_BITS:1 muxes with a register after each level, so wide/deep selects close

---
 rtl/mux_tree_pipe_n.sv | 137 +++++++++++++
 tb/tb_mux_tree_pipe_n.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_tree_pipe_n.sv
// Pipelined 2**ADDR:1 mux tree: S levels of 2**LVL_BITS:1 muxes, each followed by a
// register stage with valid/ready flow control and bubble collapsing.
module mux_tree_pipe_n #(
    parameter int N        = 4,
    parameter int ADDR     = 6,
    parameter int LVL_BITS = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    data_i [0:2**ADDR-1],
    input  logic [ADDR-1:0] sel_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [N-1:0]    data_o,
    output logic            valid_o,
    input  logic            ready_i
);

    localparam int S = (ADDR + LVL_BITS - 1) / LVL_BITS;

    function automatic int lvl_hi(input int k);
        return (k * LVL_BITS > ADDR) ? ADDR : k * LVL_BITS;
    endfunction

    function automatic int stg_cnt(input int k);
        return 1 << (ADDR - lvl_hi(k));
    endfunction

    function automatic int stg_sw(input int k);
        return ADDR - lvl_hi(k);
    endfunction

    function automatic int data_off(input int k);
        int acc;
        acc = 0;
        for (int i = 0; i < k; i++) acc += N * stg_cnt(i);
        return acc;
    endfunction

    function automatic int sel_off(input int k);
        int acc;
        acc = 0;
        for (int i = 0; i < k; i++) acc += stg_sw(i);
        return acc;
    endfunction

    localparam int DATA_BITS = data_off(S + 1);
    localparam int SEL_BITS  = sel_off(S);

    // Stage k of these buses is the input of level k; stage S carries the final result.
    logic [DATA_BITS-1:0] stg_data;
    logic [SEL_BITS-1:0]  stg_sel;
    logic [S-1:0]         vld;
    logic [S-1:0]         adv;

    for (genvar k = 0; k < 2**ADDR; k++) begin : g_in
        assign stg_data[k*N +: N] = data_i[k];
    end
    assign stg_sel[0 +: ADDR] = sel_i;

    // Unrolled form of adv[j] = !vld[j] | adv[j+1]: a level may load when downstream
    // accepts or any level from j to the output holds a bubble.
    for (genvar j = 0; j < S; j++) begin : g_adv
        assign adv[j] = ready_i | ~(&vld[S-1:j]);
    end

    for (genvar j = 0; j < S; j++) begin : g_lvl
        localparam int LO  = lvl_hi(j);
        localparam int HI  = lvl_hi(j + 1);
        localparam int W   = HI - LO;
        localparam int IC  = stg_cnt(j);
        localparam int OC  = stg_cnt(j + 1);
        localparam int ISW = stg_sw(j);
        localparam int OSW = stg_sw(j + 1);
        localparam int GRP = 1 << W;

        logic [N*IC-1:0] din;
        logic [ISW-1:0]  sin;
        logic [W-1:0]    sel_lo;
        logic            vin;
        logic [N*OC-1:0] data_d;
        logic [N*OC-1:0] data_q;
        logic            vld_q;

        assign din    = stg_data[data_off(j) +: N*IC];
        assign sin    = stg_sel[sel_off(j) +: ISW];
        assign sel_lo = sin[W-1:0];

        if (j == 0) begin : g_head
            assign vin = valid_i;
        end else begin : g_body
            assign vin = vld[j-1];
        end

        always_comb begin
            data_d = '0;
            for (int unsigned o = 0; o < OC; o++) begin
                data_d[o*N +: N] = din[(o*GRP + 32'(sel_lo))*N +: N];
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_q  <= 1'b0;
                data_q <= '0;
            end else if (adv[j]) begin
                vld_q <= vin;
                if (vin) data_q <= data_d;
            end
        end

        assign vld[j] = vld_q;
        assign stg_data[data_off(j+1) +: N*OC] = data_q;

        if (j < S - 1) begin : g_sel
            logic [OSW-1:0] sel_d;
            logic [OSW-1:0] sel_q;

            assign sel_d = sin[ISW-1:W];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sel_q <= '0;
                end else if (adv[j] && vin) begin
                    sel_q <= sel_d;
                end
            end

            assign stg_sel[sel_off(j+1) +: OSW] = sel_q;
        end
    end

    assign ready_o = adv[0];
    assign valid_o = vld[S-1];
    assign data_o  = stg_data[data_off(S) +: N];

endmodule

// File: tb/tb_mux_tree_pipe_n.sv
// Self-checking bench: directed vectors on the S=2 configuration, random scoreboard
// runs on S=1 and S=3 configurations.
module tb_mux_tree_pipe_n;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    logic rand_go;
    logic done [0:1];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Main DUT: N=8, ADDR=6, LVL_BITS=3 (S=2)
    logic [7:0] d0 [0:63];
    logic [5:0] s0;
    logic       v0, ro0, vo0, r0;
    logic [7:0] do0;

    mux_tree_pipe_n #(.N(8), .ADDR(6), .LVL_BITS(3)) u_dut (
        .clk_i(clk), .rst_i(rst), .data_i(d0), .sel_i(s0), .valid_i(v0),
        .ready_o(ro0), .data_o(do0), .valid_o(vo0), .ready_i(r0)
    );

    // Random-run DUTs: g=0 -> ADDR=5,LVL_BITS=5 (S=1); g=1 -> ADDR=7,LVL_BITS=3 (S=3)
    for (genvar g = 0; g < 2; g++) begin : g_rand
        localparam int A  = (g == 0) ? 5 : 7;
        localparam int L  = (g == 0) ? 5 : 3;
        localparam int S  = (A + L - 1) / L;
        localparam int NI = 1 << A;

        logic [7:0]   d [0:NI-1];
        logic [A-1:0] sel;
        logic         vin, rdy_o, vout, rdy_in;
        logic [7:0]   dout;

        mux_tree_pipe_n #(.N(8), .ADDR(A), .LVL_BITS(L)) u_dut (
            .clk_i(clk), .rst_i(rst), .data_i(d), .sel_i(sel), .valid_i(vin),
            .ready_o(rdy_o), .data_o(dout), .valid_o(vout), .ready_i(rdy_in)
        );

        initial begin
            logic [7:0] q_data [$];
            int         q_cyc [$];
            int         last_low;
            int         acc;
            logic       prev_stall;
            logic [7:0] prev_d;
            logic [7:0] ed;

            done[g] = 1'b0;
            vin = 1'b0;
            rdy_in = 1'b1;
            sel = '0;
            for (int k = 0; k < NI; k++) d[k] = '0;
            wait (rand_go);
            last_low = -1;
            prev_stall = 1'b0;
            prev_d = '0;
            for (int i = 0; i < 1100; i++) begin
                @(negedge clk);
                if (prev_stall) begin
                    chk("rnd_stall_valid", vout, 1);
                    chk("rnd_stall_data", dout, prev_d);
                end
                for (int k = 0; k < NI; k++) d[k] = 8'($urandom);
                if (i == 0) sel = '0;
                else if (i == 1) sel = '1;
                else sel = A'($urandom);
                vin    = (i < 1000) && ($urandom_range(0, 3) != 0);
                rdy_in = (i >= 1000) || ($urandom_range(0, 3) != 0);
                if (!rdy_in) last_low = cyc;
                #1;
                if (vin && rdy_o) begin
                    q_data.push_back(d[sel]);
                    q_cyc.push_back(cyc);
                end
                if (vout && rdy_in) begin
                    chk("rnd_pending", (q_data.size() > 0) ? 1 : 0, 1);
                    if (q_data.size() > 0) begin
                        ed  = q_data.pop_front();
                        acc = q_cyc.pop_front();
                        chk("rnd_data", dout, ed);
                        if (last_low <= acc) chk("rnd_latency", cyc, acc + S);
                    end
                end
                prev_stall = vout && !rdy_in;
                prev_d = dout;
            end
            chk("rnd_drained", q_data.size(), 0);
            done[g] = 1'b1;
        end
    end

    typedef struct {
        logic [5:0] sel;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [8];

    initial begin
        checks = 0;
        failures = 0;
        rand_go = 1'b0;
        tbl[0] = '{6'd63, 8'h7F};
        tbl[1] = '{6'd9,  8'h49};
        tbl[2] = '{6'd35, 8'h63};
        tbl[3] = '{6'd0,  8'h40};
        tbl[4] = '{6'd1,  8'h41};
        tbl[5] = '{6'd8,  8'h48};
        tbl[6] = '{6'd62, 8'h7E};
        tbl[7] = '{6'd36, 8'h64};
        for (int k = 0; k < 64; k++) d0[k] = 8'(k + 64);
        rst = 1'b1;
        v0 = 1'b0;
        s0 = '0;
        r0 = 1'b1;

        // Reset state and first-request latency
        repeat (2) @(negedge clk);
        chk("rst_valid_o", vo0, 0);
        chk("rst_data_o", do0, 0);
        chk("rst_ready_o", ro0, 1);
        rst = 1'b0;
        v0 = 1'b1;
        s0 = 6'd0;
        #1 chk("first_ready_o", ro0, 1);
        @(negedge clk);
        chk("first_not_early", vo0, 0);
        v0 = 1'b0;
        @(negedge clk);
        chk("first_valid_o", vo0, 1);
        chk("first_data_o", do0, 8'h40);

        // Back-to-back table stream, one result per cycle after 2-cycle latency
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk("b2b_valid", vo0, 1);
                chk("b2b_data", do0, tbl[i-2].exp);
            end else begin
                chk("b2b_idle", vo0, 0);
            end
            if (i < 8) begin
                v0 = 1'b1;
                s0 = tbl[i].sel;
            end else begin
                v0 = 1'b0;
            end
        end

        // Stall with three requests; a decoy select is presented while not ready
        @(negedge clk);
        r0 = 1'b0; v0 = 1'b1; s0 = 6'd5;
        #1 chk("stall_ready_0", ro0, 1);
        @(negedge clk);
        s0 = 6'd20;
        #1 chk("stall_ready_1", ro0, 1);
        @(negedge clk);
        chk("stall_valid_2", vo0, 1);
        chk("stall_data_2", do0, 8'h45);
        s0 = 6'd33;
        #1 chk("stall_ready_2", ro0, 0);
        @(negedge clk);
        chk("stall_valid_3", vo0, 1);
        chk("stall_data_3", do0, 8'h45);
        s0 = 6'd40;
        #1 chk("stall_ready_3", ro0, 0);
        @(negedge clk);
        chk("release_data_a", do0, 8'h45);
        r0 = 1'b1;
        #1 chk("release_ready", ro0, 1);
        @(negedge clk);
        v0 = 1'b0;
        chk("release_valid_b", vo0, 1);
        chk("release_data_b", do0, 8'h54);
        @(negedge clk);
        chk("release_valid_c", vo0, 1);
        chk("release_data_c", do0, 8'h68);
        @(negedge clk);
        chk("release_empty", vo0, 0);

        // Bubbles: request every other cycle
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (i >= 2) begin
                chk("bubble_valid", vo0, ((i - 2) % 2 == 0) ? 1 : 0);
                if ((i - 2) % 2 == 0) chk("bubble_data", do0, 8'(((i - 2) * 7) + 64));
            end
            v0 = (i % 2 == 0) && (i < 8);
            s0 = 6'(i * 7);
        end

        // Reset with two requests in flight
        @(negedge clk);
        v0 = 1'b1; s0 = 6'd1;
        @(negedge clk);
        s0 = 6'd2;
        @(negedge clk);
        chk("inflight_valid", vo0, 1);
        v0 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid_o", vo0, 0);
        chk("midrst_data_o", do0, 0);
        chk("midrst_ready_o", ro0, 1);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_stale", vo0, 0);
        end

        // Random runs on the S=1 and S=3 configurations
        rand_go = 1'b1;
        for (int t = 0; t < 5000 && !(done[0] && done[1]); t++) @(negedge clk);
        chk("rand_finished", (done[0] && done[1]) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
